alu_arbiter: RTL and testbench

- Shares one 8-bit combinational ALU (ops: pass, mul, or, not, add, sub, inc, dec; 3-bit select; unsigned/signed overflow outputs) between two requesters.
- Round-robin arbitration, operand latching onto the ALU inputs, a programmable settle window, then result capture with qualified overflow flags and a one-cycle done strobe tagged with the requester ID.
- Sits between the ALU instance and the two client blocks in the datapath top level.

---
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational 8-bit ALU between two requesters:
// it latches the winner's operands, waits a programmable settle window, then captures the result.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [2:0] sel0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [2:0] sel1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_uovf,
  input  logic       alu_sovf,
  output logic [7:0] result,
  output logic       res_uovf,
  output logic       res_sovf,
  output logic       done,
  output logic       done_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  // Overflow flags only carry meaning for add (100) and sub (101).
  function automatic logic [1:0] qualify_flags(input logic [2:0] sel,
                                               input logic       uovf,
                                               input logic       sovf);
    logic arith;
    arith = (sel == 3'b100) || (sel == 3'b101);
    return arith ? {uovf, sovf} : 2'b00;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_last_id, w_last_id_nxt;
  logic       r_cur_id, w_cur_id_nxt;
  logic       r_gnt0, w_gnt0_nxt;
  logic       r_gnt1, w_gnt1_nxt;
  logic [7:0] r_alu_a, w_alu_a_nxt;
  logic [7:0] r_alu_b, w_alu_b_nxt;
  logic [2:0] r_alu_sel, w_alu_sel_nxt;
  logic [7:0] r_result, w_result_nxt;
  logic       r_res_uovf, w_res_uovf_nxt;
  logic       r_res_sovf, w_res_sovf_nxt;
  logic       r_done, w_done_nxt;
  logic       r_done_id, w_done_id_nxt;
  logic       r_busy, w_busy_nxt;

  logic       w_any_req;
  logic       w_win_id;
  logic [7:0] w_win_a;
  logic [7:0] w_win_b;
  logic [2:0] w_win_sel;
  logic [1:0] w_flags;

  // On a tie the requester that did not win last time is chosen.
  assign w_any_req = req0 | req1;
  assign w_win_id  = req1 & (~req0 | ~r_last_id);
  assign w_win_a   = w_win_id ? a1   : a0;
  assign w_win_b   = w_win_id ? b1   : b0;
  assign w_win_sel = w_win_id ? sel1 : sel0;
  assign w_flags   = qualify_flags(r_alu_sel, alu_uovf, alu_sovf);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_id_nxt  = r_last_id;
    w_cur_id_nxt   = r_cur_id;
    w_gnt0_nxt     = 1'b0;
    w_gnt1_nxt     = 1'b0;
    w_alu_a_nxt    = r_alu_a;
    w_alu_b_nxt    = r_alu_b;
    w_alu_sel_nxt  = r_alu_sel;
    w_result_nxt   = r_result;
    w_res_uovf_nxt = r_res_uovf;
    w_res_sovf_nxt = r_res_sovf;
    w_done_nxt     = 1'b0;
    w_done_id_nxt  = r_done_id;
    w_busy_nxt     = r_busy;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt   = EXEC;
          w_cnt_nxt     = CNT_LOAD;
          w_cur_id_nxt  = w_win_id;
          w_last_id_nxt = w_win_id;
          w_gnt0_nxt    = ~w_win_id;
          w_gnt1_nxt    = w_win_id;
          w_alu_a_nxt   = w_win_a;
          w_alu_b_nxt   = w_win_b;
          w_alu_sel_nxt = w_win_sel;
          w_busy_nxt    = 1'b1;
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = CAPT;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      CAPT: begin
        w_result_nxt   = alu_out;
        w_res_uovf_nxt = w_flags[1];
        w_res_sovf_nxt = w_flags[0];
        w_done_nxt     = 1'b1;
        w_done_id_nxt  = r_cur_id;
        w_busy_nxt     = 1'b0;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Reset discards any in-flight operation and returns every output to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_last_id  <= 1'b1;
      r_cur_id   <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_alu_a    <= 8'd0;
      r_alu_b    <= 8'd0;
      r_alu_sel  <= 3'b000;
      r_result   <= 8'd0;
      r_res_uovf <= 1'b0;
      r_res_sovf <= 1'b0;
      r_done     <= 1'b0;
      r_done_id  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_id  <= w_last_id_nxt;
      r_cur_id   <= w_cur_id_nxt;
      r_gnt0     <= w_gnt0_nxt;
      r_gnt1     <= w_gnt1_nxt;
      r_alu_a    <= w_alu_a_nxt;
      r_alu_b    <= w_alu_b_nxt;
      r_alu_sel  <= w_alu_sel_nxt;
      r_result   <= w_result_nxt;
      r_res_uovf <= w_res_uovf_nxt;
      r_res_sovf <= w_res_sovf_nxt;
      r_done     <= w_done_nxt;
      r_done_id  <= w_done_id_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_sel  = r_alu_sel;
  assign result   = r_result;
  assign res_uovf = r_res_uovf;
  assign res_sovf = r_res_sovf;
  assign done     = r_done;
  assign done_id  = r_done_id;
  assign busy     = r_busy;

  a_exec_range: assert property (@(posedge clk) (EXEC_CYCLES >= 1) && (EXEC_CYCLES <= 15));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (settle window 1 and 3) driven by requester agents,
// checked every cycle against a transaction-level timing model plus hand-computed pins.
module tb_alu_arbiter;

  localparam int EX_A = 1;
  localparam int EX_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0_d [2], req1_d [2];
  logic [7:0] a0_d [2], b0_d [2], a1_d [2], b1_d [2];
  logic [2:0] sel0_d [2], sel1_d [2];
  logic       gnt0_d [2], gnt1_d [2], done_d [2], done_id_d [2], busy_d [2];
  logic       res_uovf_d [2], res_sovf_d [2], alu_uovf_d [2], alu_sovf_d [2];
  logic [7:0] alu_a_d [2], alu_b_d [2], result_d [2], alu_out_d [2];
  logic [2:0] alu_sel_d [2];

  // Reference ALU: {uovf, sovf, out}. Non add/sub ops raise flags so masking is visible.
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] s);
    logic [8:0]  w;
    logic [15:0] m;
    logic [7:0]  y;
    logic        u, v;
    u = 1'b1; v = 1'b1; y = 8'd0; w = 9'd0; m = 16'd0;
    case (s)
      3'd0: y = a;
      3'd1: begin m = 16'(a) * 16'(b); y = m[7:0]; u = (m[15:8] != 8'd0); end
      3'd2: y = a | b;
      3'd3: y = ~a;
      3'd4: begin w = {1'b0, a} + {1'b0, b}; y = w[7:0]; u = w[8];
                  v = (a[7] == b[7]) && (y[7] != a[7]); end
      3'd5: begin w = {1'b0, a} - {1'b0, b}; y = w[7:0]; u = w[8];
                  v = (a[7] != b[7]) && (y[7] != a[7]); end
      3'd6: y = a + 8'd1;
      default: y = a - 8'd1;
    endcase
    return {u, v, y};
  endfunction

  assign {alu_uovf_d[0], alu_sovf_d[0], alu_out_d[0]} = alu_f(alu_a_d[0], alu_b_d[0], alu_sel_d[0]);
  assign {alu_uovf_d[1], alu_sovf_d[1], alu_out_d[1]} = alu_f(alu_a_d[1], alu_b_d[1], alu_sel_d[1]);

  alu_arbiter #(.EXEC_CYCLES(EX_A)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_d[0]), .a0(a0_d[0]), .b0(b0_d[0]), .sel0(sel0_d[0]),
    .req1(req1_d[0]), .a1(a1_d[0]), .b1(b1_d[0]), .sel1(sel1_d[0]),
    .gnt0(gnt0_d[0]), .gnt1(gnt1_d[0]),
    .alu_a(alu_a_d[0]), .alu_b(alu_b_d[0]), .alu_sel(alu_sel_d[0]),
    .alu_out(alu_out_d[0]), .alu_uovf(alu_uovf_d[0]), .alu_sovf(alu_sovf_d[0]),
    .result(result_d[0]), .res_uovf(res_uovf_d[0]), .res_sovf(res_sovf_d[0]),
    .done(done_d[0]), .done_id(done_id_d[0]), .busy(busy_d[0])
  );

  alu_arbiter #(.EXEC_CYCLES(EX_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_d[1]), .a0(a0_d[1]), .b0(b0_d[1]), .sel0(sel0_d[1]),
    .req1(req1_d[1]), .a1(a1_d[1]), .b1(b1_d[1]), .sel1(sel1_d[1]),
    .gnt0(gnt0_d[1]), .gnt1(gnt1_d[1]),
    .alu_a(alu_a_d[1]), .alu_b(alu_b_d[1]), .alu_sel(alu_sel_d[1]),
    .alu_out(alu_out_d[1]), .alu_uovf(alu_uovf_d[1]), .alu_sovf(alu_sovf_d[1]),
    .result(result_d[1]), .res_uovf(res_uovf_d[1]), .res_sovf(res_sovf_d[1]),
    .done(done_d[1]), .done_id(done_id_d[1]), .busy(busy_d[1])
  );

  function automatic int exk(input int k);
    return (k == 0) ? EX_A : EX_B;
  endfunction

  // Output vector layout: gnt0 gnt1 alu_a alu_b alu_sel result uovf sovf done done_id busy
  function automatic logic [33:0] pk(input logic g0, input logic g1, input logic [7:0] a,
                                     input logic [7:0] b, input logic [2:0] sl,
                                     input logic [7:0] r, input logic u, input logic s,
                                     input logic d, input logic id, input logic by);
    return {g0, g1, a, b, sl, r, u, s, d, id, by};
  endfunction

  localparam logic [33:0] M_RES  = 34'h00000_1FFE;
  localparam logic [33:0] M_GNT  = 34'h3_0000_0000;
  localparam logic [33:0] M_DONE = 34'h00000_0004;
  localparam logic [33:0] M_BUSY = 34'h00000_0001;
  localparam logic [33:0] M_ALL  = '1;

  // Model: operations are timestamped; an op granted at edge E completes at edge E+EX+1.
  int         edge_n = 0;
  logic       e_g0 [2] = '{0, 0}, e_g1 [2] = '{0, 0}, e_done [2] = '{0, 0};
  logic       e_u [2] = '{0, 0}, e_s [2] = '{0, 0}, e_id [2] = '{0, 0}, e_busy [2] = '{0, 0};
  logic [7:0] e_a [2] = '{0, 0}, e_b [2] = '{0, 0}, e_res [2] = '{0, 0};
  logic [2:0] e_sel [2] = '{0, 0};
  logic       lastid [2] = '{1, 1}, opid [2] = '{0, 0}, pend [2] = '{0, 0};
  int         dedge [2] = '{0, 0};

  always @(posedge clk) begin
    logic [9:0] r10;
    logic       arith, w;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      e_g0[k] = 1'b0; e_g1[k] = 1'b0; e_done[k] = 1'b0;
      if (rst) begin
        e_a[k] = 8'd0; e_b[k] = 8'd0; e_sel[k] = 3'd0; e_res[k] = 8'd0;
        e_u[k] = 1'b0; e_s[k] = 1'b0; e_id[k] = 1'b0; e_busy[k] = 1'b0;
        lastid[k] = 1'b1; pend[k] = 1'b0;
      end else if (pend[k]) begin
        if (edge_n == dedge[k]) begin
          r10 = alu_f(e_a[k], e_b[k], e_sel[k]);
          arith = (e_sel[k] == 3'd4) || (e_sel[k] == 3'd5);
          e_res[k] = r10[7:0];
          e_u[k] = arith & r10[9];
          e_s[k] = arith & r10[8];
          e_done[k] = 1'b1; e_id[k] = opid[k]; e_busy[k] = 1'b0; pend[k] = 1'b0;
        end
      end else if (req0_d[k] || req1_d[k]) begin
        w = (req0_d[k] && req1_d[k]) ? ~lastid[k] : req1_d[k];
        lastid[k] = w; opid[k] = w;
        e_g0[k] = ~w; e_g1[k] = w;
        e_a[k] = w ? a1_d[k] : a0_d[k];
        e_b[k] = w ? b1_d[k] : b0_d[k];
        e_sel[k] = w ? sel1_d[k] : sel0_d[k];
        e_busy[k] = 1'b1; pend[k] = 1'b1;
        dedge[k] = edge_n + exk(k) + 1;
      end
    end
  end

  typedef struct {
    int          at;
    int          k;
    logic [33:0] m;
    logic [33:0] v;
    string       nm;
  } pin_t;
  pin_t pins[$];

  int   n_chk = 0;
  int   n_pass = 0;
  logic chk_en = 1'b0;

  always @(negedge clk) begin
    logic [33:0] act, exp;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        act = pk(gnt0_d[k], gnt1_d[k], alu_a_d[k], alu_b_d[k], alu_sel_d[k], result_d[k],
                 res_uovf_d[k], res_sovf_d[k], done_d[k], done_id_d[k], busy_d[k]);
        exp = pk(e_g0[k], e_g1[k], e_a[k], e_b[k], e_sel[k], e_res[k],
                 e_u[k], e_s[k], e_done[k], e_id[k], e_busy[k]);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL outputs cfg%0d edge %0d: got %h, model %h", k, edge_n, act, exp);
        foreach (pins[i]) begin
          if (pins[i].at == edge_n && pins[i].k == k) begin
            n_chk++;
            if ((act & pins[i].m) === (pins[i].v & pins[i].m)) n_pass++;
            else $display("FAIL %s cfg%0d edge %0d: got %h, required %h (mask %h)", pins[i].nm,
                          k, edge_n, act & pins[i].m, pins[i].v & pins[i].m, pins[i].m);
          end
        end
      end
    end
  end

  task automatic add_pin(input int at, input int k, input logic [33:0] m,
                         input logic [33:0] v, input string nm);
    pin_t p;
    p.at = at; p.k = k; p.m = m; p.v = v; p.nm = nm;
    pins.push_back(p);
  endtask

  task automatic pin_done(input int at, input int k, input logic [7:0] r, input logic u,
                          input logic s, input logic id, input string nm);
    add_pin(at, k, M_RES, pk(0, 0, 8'd0, 8'd0, 3'd0, r, u, s, 1'b1, id, 1'b0), nm);
  endtask

  task automatic set_req(input int k, input int s, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] sl);
    if (s == 0) begin
      req0_d[k] = v; a0_d[k] = a; b0_d[k] = b; sel0_d[k] = sl;
    end else begin
      req1_d[k] = v; a1_d[k] = a; b1_d[k] = b; sel1_d[k] = sl;
    end
  endtask

  task automatic wait_gnt(input int k, input int s, output int e);
    e = -1;
    for (int i = 0; i < 40 && e < 0; i++) begin
      @(negedge clk);
      if (((s == 0) ? gnt0_d[k] : gnt1_d[k]) === 1'b1) e = edge_n;
    end
    if (e < 0) begin
      $display("FAIL grant timeout cfg%0d side%0d: no gnt within 40 cycles", k, s);
      $fatal(1, "grant timeout");
    end
  endtask

  task automatic issue(input int k, input int s, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sl, output int e);
    set_req(k, s, 1'b1, a, b, sl);
    wait_gnt(k, s, e);
    set_req(k, s, 1'b0, a, b, sl);
  endtask

  initial begin
    int e, r;
    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 1'b0, 8'd0, 8'd0, 3'd0);
      set_req(k, 1, 1'b0, 8'd0, 8'd0, 3'd0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    add_pin(edge_n, 0, M_ALL, 34'd0, "reset_state");
    add_pin(edge_n, 1, M_ALL, 34'd0, "reset_state");
    rst = 1'b0;

    issue(0, 0, 8'h7F, 8'h01, 3'b100, e);
    pin_done(e + 2, 0, 8'h80, 1'b0, 1'b1, 1'b0, "add_sovf");
    issue(0, 1, 8'h00, 8'h01, 3'b101, e);
    pin_done(e + 2, 0, 8'hFF, 1'b1, 1'b0, 1'b1, "sub_borrow");
    issue(0, 0, 8'h10, 8'h10, 3'b001, e);
    pin_done(e + 2, 0, 8'h00, 1'b0, 1'b0, 1'b0, "mul_flag_mask");
    repeat (3) @(negedge clk);

    // Contention on the 1-cycle instance right after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r = edge_n;
    for (int j = 0; j < 4; j++) begin
      add_pin(r + 1 + 3 * j, 0, M_GNT, pk(j % 2 == 0, j % 2 == 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              "contention_gnt");
      if (j % 2 == 0) pin_done(r + 3 + 3 * j, 0, 8'h26, 1'b0, 1'b0, 1'b0, "contention_done");
      else            pin_done(r + 3 + 3 * j, 0, 8'h20, 1'b1, 1'b1, 1'b1, "contention_done");
    end
    set_req(0, 0, 1'b1, 8'h21, 8'h05, 3'b100);
    set_req(0, 1, 1'b1, 8'h90, 8'h90, 3'b100);
    while (edge_n < r + 12) @(negedge clk);
    set_req(0, 0, 1'b0, 8'h21, 8'h05, 3'b100);
    set_req(0, 1, 1'b0, 8'h90, 8'h90, 3'b100);

    // Reset during EXEC on the 3-cycle instance; last winner before reset is requester 0
    issue(1, 0, 8'h12, 8'h34, 3'b100, e);
    rst = 1'b1;
    add_pin(e + 1, 1, M_ALL, 34'd0, "reset_mid_op");
    add_pin(e + 4, 1, M_DONE, 34'd0, "no_done_after_reset");
    @(negedge clk);
    rst = 1'b0;
    add_pin(edge_n + 1, 1, M_GNT, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "first_tie_after_reset");
    set_req(1, 0, 1'b1, 8'h01, 8'h02, 3'b010);
    set_req(1, 1, 1'b1, 8'h03, 8'h04, 3'b000);
    wait_gnt(1, 0, e);
    set_req(1, 0, 1'b0, 8'h01, 8'h02, 3'b010);
    wait_gnt(1, 1, e);
    set_req(1, 1, 1'b0, 8'h03, 8'h04, 3'b000);
    repeat (6) @(negedge clk);

    // Latency with a 3-cycle settle window: busy for 4 cycles, then done
    r = edge_n;
    for (int j = 0; j < 4; j++)
      add_pin(r + 1 + j, 1, M_BUSY | M_DONE, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "latency_busy");
    add_pin(r + 5, 1, M_RES | M_BUSY, pk(0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0), "latency_done");
    issue(1, 0, 8'hFF, 8'h00, 3'b110, e);
    repeat (6) @(negedge clk);

    // Randomized requester agents on both instances
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < 2; s++) begin
          logic g, cur;
          g   = (s == 0) ? gnt0_d[k] : gnt1_d[k];
          cur = (s == 0) ? req0_d[k] : req1_d[k];
          if (cur && g)
            set_req(k, s, ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom),
                    3'($urandom_range(0, 7)));
          else if (!cur && $urandom_range(0, 3) == 0)
            set_req(k, s, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 1'b0, 8'd0, 8'd0, 3'd0);
      set_req(k, 1, 1'b0, 8'd0, 8'd0, 3'd0);
    end
    repeat (10) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
